// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//
// Upstream stage of the systolic array. Accepts one A column-slice and one
// B row-slice per beat (valid/ready handshake) and skews them diagonally:
// lane k reaches the array k cycles later than lane 0. After the requested
// number of inner-dimension beats it flushes zeros until the last operand
// has reached PE(N-1,N-1), then pulses done_o so draining can begin.
//
// Ports
//   clk_i       in   1         clock, all state on rising edge
//   rst_i       in   1         asynchronous active-low reset
//   start_i     in   1         begin a tile (sampled only in IDLE)
//   k_len_i     in   K_W       beats for this tile, latched with start_i
//   in_valid_i  in   1         a_vec_i/b_vec_i hold a beat
//   in_ready_o  out  1         feeder accepts a beat this cycle
//   a_vec_i     in   N*DATA_W  A column slice, lane k = row k
//   b_vec_i     in   N*DATA_W  B row slice, lane k = column k
//   a_o         out  N*DATA_W  skewed A to the array
//   b_o         out  N*DATA_W  skewed B to the array
//   busy_o      out  1         a tile is in progress
//   done_o      out  1         one-cycle pulse: tile injected and propagated
// ---------------------------------------------------------------------------
module systolic_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int K_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [K_W-1:0]      k_len_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [N*DATA_W-1:0] a_vec_i,
    input  logic [N*DATA_W-1:0] b_vec_i,
    output logic [N*DATA_W-1:0] a_o,
    output logic [N*DATA_W-1:0] b_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH,
        DONE
    } state_t;

    // The flush has to cover 2N-1 cycles so the last beat on the deepest
    // lane can walk across the whole array diagonal.
    localparam int FLUSH_W = $clog2(2 * N);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(2 * N - 2);

    state_t             state;
    logic [K_W-1:0]     k_len;
    logic [K_W-1:0]     beat_cnt;
    logic [FLUSH_W-1:0] flush_cnt;
    logic               accept;

    // Handshake and status flags decode straight from the state register,
    // so reset clears them in the same cycle it is asserted.
    assign in_ready_o = (state == FEED);
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);
    assign accept     = in_valid_i & in_ready_o;

    // Tile sequencer. A zero-length tile goes straight to DONE with no flush
    // since nothing was injected. In FEED the last beat is the one accepted
    // while beat_cnt still reads k_len-1, which keeps beat_cnt from ever
    // counting past k_len.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            k_len     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (k_len_i != '0) begin
                            state    <= FEED;
                            k_len    <= k_len_i;
                            beat_cnt <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FEED: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + K_W'(1);
                        if (beat_cnt == k_len - K_W'(1)) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-lane skew chains. Lane k is k+1 registers deep. Every chain shifts
    // every cycle in every state; when no beat is accepted a zero enters on
    // all lanes, so A/B pairing inside the array stays aligned through
    // bubbles and the flush.
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [DATA_W-1:0] a_pipe [0:k];
        logic [DATA_W-1:0] b_pipe [0:k];
        logic [DATA_W-1:0] a_in;
        logic [DATA_W-1:0] b_in;

        assign a_in = accept ? a_vec_i[k*DATA_W +: DATA_W] : '0;
        assign b_in = accept ? b_vec_i[k*DATA_W +: DATA_W] : '0;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                for (int s = 0; s <= k; s++) begin
                    a_pipe[s] <= '0;
                    b_pipe[s] <= '0;
                end
            end else begin
                a_pipe[0] <= a_in;
                b_pipe[0] <= b_in;
                for (int s = 1; s <= k; s++) begin
                    a_pipe[s] <= a_pipe[s-1];
                    b_pipe[s] <= b_pipe[s-1];
                end
            end
        end

        assign a_o[k*DATA_W +: DATA_W] = a_pipe[k];
        assign b_o[k*DATA_W +: DATA_W] = b_pipe[k];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
//
// Directed bench for systolic_feeder with N=4, DATA_W=8. Cycle c is the
// clock period that ends with rising edge c; the tile's start_i is sampled
// at edge 0. Inputs are driven #1 after each rising edge and outputs are
// observed at that same point, i.e. the values the DUT holds for cycle c.
// Beat j (1-based) of a tile carries lane k value (j-1)*16+k+1 on A and the
// same plus 0x80 on B, so every lane/beat is distinguishable.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int K_W    = 16;
    localparam logic [N*DATA_W-1:0] JUNK = 32'hEEEE_EEEE;

    logic                clk_i;
    logic                rst_i;
    logic                start_i;
    logic [K_W-1:0]      k_len_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [N*DATA_W-1:0] a_vec_i;
    logic [N*DATA_W-1:0] b_vec_i;
    logic [N*DATA_W-1:0] a_o;
    logic [N*DATA_W-1:0] b_o;
    logic                busy_o;
    logic                done_o;

    int assert_cnt;
    int fail_cnt;
    int acc_cycle [4];
    int acc_n;

    systolic_feeder #(
        .N      (N),
        .DATA_W (DATA_W),
        .K_W    (K_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .k_len_i    (k_len_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_vec_i    (a_vec_i),
        .b_vec_i    (b_vec_i),
        .a_o        (a_o),
        .b_o        (b_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // Free-running 10-unit clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Operand value carried on lane k by beat j of a tile.
    function automatic logic [DATA_W-1:0] beat_val(input int j, input int k, input bit is_b);
        return DATA_W'((j - 1) * 16 + k + 1 + (is_b ? 128 : 0));
    endfunction

    // Full input vector for beat j.
    function automatic logic [N*DATA_W-1:0] in_vec(input int j, input bit is_b);
        logic [N*DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = beat_val(j, k, is_b);
        return v;
    endfunction

    // Expected skewed output in cycle c: lane k shows the beat accepted at
    // edge c-1-k, or zero if nothing was accepted at that edge.
    function automatic logic [N*DATA_W-1:0] exp_vec(input int c, input bit is_b);
        logic [N*DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < acc_n; i++) begin
                if (acc_cycle[i] == c - 1 - k) v[k*DATA_W +: DATA_W] = beat_val(i + 1, k, is_b);
            end
        end
        return v;
    endfunction

    // Drive one cycle of inputs, clock them in, land #1 after the edge.
    task automatic apply_stimulus(input logic st, input logic [K_W-1:0] kl, input logic v,
                                  input logic [N*DATA_W-1:0] a, input logic [N*DATA_W-1:0] b);
        start_i    = st;
        k_len_i    = kl;
        in_valid_i = v;
        a_vec_i    = a;
        b_vec_i    = b;
        @(posedge clk_i);
        #1;
    endtask

    // One comparison point.
    task automatic check_output(input string tag, input logic [N*DATA_W-1:0] obs,
                                input logic [N*DATA_W-1:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the full output set for cycle c of the current tile.
    task automatic check_cycle(input string name, input int c, input logic exp_ready,
                               input logic exp_busy, input logic exp_done);
        check_output($sformatf("%s c%0d a_o", name, c), a_o, exp_vec(c, 1'b0));
        check_output($sformatf("%s c%0d b_o", name, c), b_o, exp_vec(c, 1'b1));
        check_output($sformatf("%s c%0d in_ready", name, c), {31'b0, in_ready_o}, {31'b0, exp_ready});
        check_output($sformatf("%s c%0d busy", name, c), {31'b0, busy_o}, {31'b0, exp_busy});
        check_output($sformatf("%s c%0d done", name, c), {31'b0, done_o}, {31'b0, exp_done});
    endtask

    initial begin
        logic v;
        assert_cnt = 0;
        fail_cnt   = 0;
        acc_n      = 0;
        rst_i      = 1'b0;
        start_i    = 1'b0;
        k_len_i    = '0;
        in_valid_i = 1'b0;
        a_vec_i    = '0;
        b_vec_i    = '0;

        $display("[TB] reset state");
        repeat (2) @(posedge clk_i);
        #1;
        check_cycle("reset", 0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        apply_stimulus(1'b0, '0, 1'b1, JUNK, JUNK);
        apply_stimulus(1'b0, '0, 1'b1, JUNK, JUNK);
        check_cycle("idle", 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] single beat, k_len=1");
        acc_n = 1;
        acc_cycle[0] = 1;
        apply_stimulus(1'b1, 16'd1, 1'b0, JUNK, JUNK);
        check_cycle("single", 1, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, in_vec(1, 1'b0), in_vec(1, 1'b1));
        for (int c = 2; c <= 10; c++) begin
            check_cycle("single", c, 1'b0, (c <= 9), (c == 9));
            apply_stimulus(1'b0, '0, 1'b0, JUNK, JUNK);
        end

        $display("[TB] bubbles, k_len=3, valid 1,0,1,0,1");
        acc_n = 3;
        acc_cycle[0] = 1;
        acc_cycle[1] = 3;
        acc_cycle[2] = 5;
        apply_stimulus(1'b1, 16'd3, 1'b0, JUNK, JUNK);
        for (int c = 1; c <= 14; c++) begin
            check_cycle("bubble", c, (c <= 5), (c <= 13), (c == 13));
            v = (c <= 5) && (c % 2 == 1);
            if (v) apply_stimulus(1'b0, '0, 1'b1, in_vec((c + 1) / 2, 1'b0), in_vec((c + 1) / 2, 1'b1));
            else   apply_stimulus(1'b0, '0, 1'b0, JUNK, JUNK);
        end
        check_cycle("bubble", 15, 1'b0, 1'b0, 1'b0);

        $display("[TB] k_len=0");
        acc_n = 0;
        apply_stimulus(1'b1, 16'd0, 1'b1, JUNK, JUNK);
        check_cycle("klen0", 1, 1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, JUNK, JUNK);
        check_cycle("klen0", 2, 1'b0, 1'b0, 1'b0);

        $display("[TB] start re-asserted mid-tile");
        acc_n = 2;
        acc_cycle[0] = 1;
        acc_cycle[1] = 2;
        apply_stimulus(1'b1, 16'd2, 1'b0, JUNK, JUNK);
        for (int c = 1; c <= 11; c++) begin
            check_cycle("restart", c, (c <= 2), (c <= 10), (c == 10));
            if (c <= 2)
                apply_stimulus((c == 1 || c == 2), 16'd5, 1'b1, in_vec(c, 1'b0), in_vec(c, 1'b1));
            else
                apply_stimulus((c == 4), 16'd7, (c <= 5), JUNK, JUNK);
        end
        check_cycle("restart", 12, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during FEED");
        acc_n = 2;
        acc_cycle[0] = 1;
        acc_cycle[1] = 2;
        apply_stimulus(1'b1, 16'd4, 1'b0, JUNK, JUNK);
        apply_stimulus(1'b0, '0, 1'b1, in_vec(1, 1'b0), in_vec(1, 1'b1));
        apply_stimulus(1'b0, '0, 1'b1, in_vec(2, 1'b0), in_vec(2, 1'b1));
        check_cycle("prereset", 3, 1'b1, 1'b1, 1'b0);
        in_valid_i = 1'b0;
        #1;
        rst_i = 1'b0;
        #1;
        acc_n = 0;
        check_cycle("midreset", 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'd2, 1'b1, JUNK, JUNK);
        check_cycle("inreset", 0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b0, '0, 1'b1, in_vec(3, 1'b0), in_vec(3, 1'b1));
            check_cycle("postreset", c, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
